// File: rtl/pipe_ctrl.sv
// pipe_ctrl - sequencing controller for the 3-stage core (IF, X, MW).
//
// Decides stall, kill and redirect for the X/MW pipeline and runs the
// data-cache request handshake for loads/stores resident in MW.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   valid_x, opcode_x   stage-2 instruction valid flag and 7-bit opcode
//   br_taken_x          branch comparator result for the stage-2 instruction
//   mem_req_mw          stage 3 holds a load/store; mem_we_mw = 1 for store
//   icache_resp_valid   fetched instruction available this cycle
//   dcache_req_ready    dcache accepts the request this cycle
//   dcache_resp_valid   load data returned this cycle
//   dcache_req_valid    request to dcache
//   stall               hold PC, IF/X, X/MW registers and RegFile write
//   redirect / kill_x   take branch/jump target, squash instruction entering X
//   ld_capture          stage 3 latches dcache read data into its hold register
//   ld_hold_sel         stage-3 writeback data comes from the hold register
//   state               FSM state (debug)
//   stall_cycles, redirect_count  saturating perf counters (PIPE_CTRL_PERF_EN)
//
// Optional feature macro: PIPE_CTRL_PERF_EN enables the performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_x,
    input  logic [6:0]       opcode_x,
    input  logic             br_taken_x,
    input  logic             mem_req_mw,
    input  logic             mem_we_mw,
    input  logic             icache_resp_valid,
    input  logic             dcache_req_ready,
    input  logic             dcache_resp_valid,
    output logic             dcache_req_valid,
    output logic             stall,
    output logic             redirect,
    output logic             kill_x,
    output logic             ld_capture,
    output logic             ld_hold_sel,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count,
`endif
    output logic [1:0]       state
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DREQ  = 2'd1,
        DRESP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_r;

    logic req_s;
    logic stall_s;
    logic cap_s;
    logic hold_s;
    logic jump_s;

    // Per-state handshake and stall decode (pre-reset-gating).
    always_comb begin
        req_s   = 1'b0;
        stall_s = 1'b0;
        cap_s   = 1'b0;
        hold_s  = 1'b0;
        case (state_r)
            RUN: begin
                req_s   = mem_req_mw;
                // A load always waits for data; a store only for acceptance.
                stall_s = (mem_req_mw & (~dcache_req_ready | ~mem_we_mw)) | ~icache_resp_valid;
            end
            DREQ: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
            end
            DRESP: begin
                stall_s = 1'b1;
                cap_s   = dcache_resp_valid;
            end
            DONE: begin
                hold_s  = 1'b1;
                stall_s = ~icache_resp_valid;
            end
            default: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
                cap_s   = 1'b0;
                hold_s  = 1'b0;
            end
        endcase
    end

    // Control-flow change detection for the X-stage instruction.
    always_comb begin
        jump_s = (opcode_x == OP_JAL) | (opcode_x == OP_JALR) |
                 ((opcode_x == OP_BRANCH) & br_taken_x);
    end

    // Outputs are forced low while reset is asserted so nothing escapes
    // to the caches or PC mux before the FSM is known to be in RUN.
    always_comb begin
        dcache_req_valid = req_s & ~reset;
        stall            = stall_s & ~reset;
        ld_capture       = cap_s & ~reset;
        ld_hold_sel      = hold_s & ~reset;
        // A stalled branch stays in X and resolves once the stall drops.
        redirect         = valid_x & ~stall_s & jump_s & ~reset;
        kill_x           = valid_x & ~stall_s & jump_s & ~reset;
        state            = state_r;
    end

    // Sequencing FSM following the dcache handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_req_mw) begin
                        if (!dcache_req_ready) begin
                            state_r <= DREQ;
                        end else if (!mem_we_mw) begin
                            state_r <= DRESP;
                        end else if (!icache_resp_valid) begin
                            // Accepted store must not be re-issued while IF stalls.
                            state_r <= DONE;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DREQ: begin
                    if (dcache_req_ready) begin
                        state_r <= mem_we_mw ? DONE : DRESP;
                    end else begin
                        state_r <= DREQ;
                    end
                end
                DRESP: begin
                    if (dcache_resp_valid) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= DRESP;
                    end
                end
                DONE: begin
                    if (icache_resp_valid) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating stall and redirect event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles   <= {CNT_W{1'b0}};
            redirect_count <= {CNT_W{1'b0}};
        end else begin
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (redirect && (redirect_count != {CNT_W{1'b1}})) begin
                redirect_count <= redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                redirect_count <= redirect_count;
            end
        end
    end
`endif

endmodule
